// File: rtl/m_calc_unit.sv
// m_calc_unit: consumes CGES signed operand pairs per cal run and
// accumulates their products; pulses fin with the held result, then
// waits for cal to drop before it can be started again.
module m_calc_unit #(
    parameter int unsigned  CGES = 7,
    parameter int unsigned  DW   = 16,
    localparam int unsigned AW   = 2 * DW + $clog2(CGES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cal,
    input  logic          in_valid,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          in_ready,
    output logic          fin,
    output logic [AW-1:0] result,
    output logic          busy,
    output logic          abort
);

    localparam int unsigned IW = $clog2(CGES + 1);
    localparam int unsigned PW = 2 * DW;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MAC     = 2'd1,
        S_DONE    = 2'd2,
        S_WAITLOW = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] result_d;
    logic signed [AW-1:0] acc_sum;
    logic        [IW-1:0] idx_q;
    logic        [IW-1:0] idx_d;
    logic signed [PW-1:0] prod;
    logic                 fin_d;
    logic                 abort_d;
    logic                 busy_d;

    // Full-width signed product; operands widened first so -2^(DW-1)^2 is exact.
    assign prod    = PW'($signed(in_a)) * PW'($signed(in_b));
    assign acc_sum = acc_q + AW'(prod);

    // Ready is a live view of cal while accumulating, so a dropping cal blocks the pair.
    assign in_ready = (state_q == S_MAC) && cal;

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result;
        fin_d    = 1'b0;
        abort_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cal) begin
                    state_d  = S_MAC;
                    acc_d    = '0;
                    idx_d    = '0;
                    result_d = '0;
                end
            end
            S_MAC: begin
                if (!cal) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    idx_d   = '0;
                    abort_d = 1'b1;
                end else if (in_valid) begin
                    acc_d = acc_sum;
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IW'(CGES - 1)) begin
                        state_d  = S_DONE;
                        fin_d    = 1'b1;
                        result_d = acc_sum;
                    end
                end
            end
            S_DONE: begin
                state_d = S_WAITLOW;
            end
            S_WAITLOW: begin
                if (!cal) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_MAC) || (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            result  <= '0;
            fin     <= 1'b0;
            abort   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            result  <= result_d;
            fin     <= fin_d;
            abort   <= abort_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_m_calc_unit.sv
// Testbench for m_calc_unit: directed and randomized runs checked against
// a sum-of-products model evaluated with 64-bit integer arithmetic.
module tb_m_calc_unit;

    localparam int CGES = 7;
    localparam int DW   = 16;
    localparam int AW   = 2 * DW + 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cal;
    logic          in_valid;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_ready;
    logic          fin;
    logic [AW-1:0] result;
    logic          busy;
    logic          abort;

    int checks   = 0;
    int failures = 0;
    int va [CGES];
    int vb [CGES];

    m_calc_unit #(.CGES(CGES), .DW(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cal      (cal),
        .in_valid (in_valid),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_ready (in_ready),
        .fin      (fin),
        .result   (result),
        .busy     (busy),
        .abort    (abort)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic longint model_sum();
        longint s = 0;
        for (int i = 0; i < CGES; i++) s += longint'(va[i]) * longint'(vb[i]);
        return s;
    endfunction

    function automatic int rand_s16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    // Full run: start, CGES handshakes (mode 0 continuous, 1 toggling, 2 random),
    // fin timing/result checks, then optionally drop cal and let the engine re-arm.
    task automatic run_pairs(input int mode, input longint exp, input bit keep_cal, input string name);
        int n = 0;
        int cyc = 0;
        bit v;
        logic [AW-1:0] exp_r;
        exp_r = AW'(exp);
        cal = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_start_busy got=%b exp=1", name, busy);
        end
        while (n < CGES && cyc < 300) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = (cyc > 100) ? 1'b1 : ($urandom_range(0, 1) == 1);
            endcase
            in_valid = v;
            in_a = v ? 16'(va[n]) : 16'($urandom);
            in_b = v ? 16'(vb[n]) : 16'($urandom);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s_ready cyc=%0d got=%b exp=1", name, cyc, in_ready);
            end
            @(negedge clk);
            cyc++;
            if (v) n++;
            checks++;
            if (fin !== (n == CGES)) begin
                failures++;
                $display("FAIL %s_fin_timing hs=%0d got=%b exp=%b", name, n, fin, (n == CGES));
            end
        end
        if (n < CGES) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout handshakes=%0d exp=%0d", name, n, CGES);
        end
        checks++;
        if (result !== exp_r) begin
            failures++;
            $display("FAIL %s_result got=%0d exp=%0d", name, $signed(result), exp);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_busy got=%b exp=1", name, busy);
        end
        in_valid = 1'b1;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        if (!keep_cal) begin
            cal = 1'b0;
            @(negedge clk);
            checks++;
            if (fin !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || result !== exp_r) begin
                failures++;
                $display("FAIL %s_post fin=%b busy=%b rdy=%b res=%0d exp=0,0,0,%0d",
                         name, fin, busy, in_ready, $signed(result), exp);
            end
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    // Drive n back-to-back handshakes while in MAC, checking fin stays low.
    task automatic feed(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            @(negedge clk);
            checks++;
            if (fin !== 1'b0) begin
                failures++;
                $display("FAIL %s_early_fin hs=%0d got=%b exp=0", name, i + 1, fin);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cal = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (fin !== 1'b0 || abort !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL reset_values fin=%b abort=%b busy=%b rdy=%b res=%0d exp all 0",
                     fin, abort, busy, in_ready, result);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b rdy=%b exp=0,0", busy, in_ready);
        end
    endtask

    task automatic test_continuous();
        for (int i = 0; i < CGES; i++) begin va[i] = i + 1; vb[i] = 2; end
        run_pairs(0, 56, 1'b0, "continuous");
    endtask

    task automatic test_toggle();
        for (int i = 0; i < CGES; i++) begin va[i] = i + 1; vb[i] = 2; end
        run_pairs(1, 56, 1'b0, "toggle");
    endtask

    task automatic test_extremes();
        for (int i = 0; i < CGES; i++) begin va[i] = -32768; vb[i] = -32768; end
        run_pairs(0, 64'sd7516192768, 1'b0, "max_pos");
        for (int i = 0; i < CGES; i++) begin va[i] = 32767; vb[i] = -32768; end
        run_pairs(0, -(64'sd7 * 64'sd32767 * 64'sd32768), 1'b0, "max_neg");
    endtask

    task automatic test_abort();
        cal = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        feed(3, "abort");
        cal = 1'b0;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_ready got=%b exp=0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (abort !== 1'b1 || fin !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_pulse abort=%b fin=%b busy=%b exp=1,0,0", abort, fin, busy);
        end
        @(negedge clk);
        checks++;
        if (abort !== 1'b0 || fin !== 1'b0) begin
            failures++;
            $display("FAIL abort_single abort=%b fin=%b exp=0,0", abort, fin);
        end
        for (int i = 0; i < CGES; i++) begin va[i] = i + 1; vb[i] = 1; end
        run_pairs(0, 28, 1'b0, "after_abort");
    endtask

    task automatic test_hold();
        for (int i = 0; i < CGES; i++) begin va[i] = i + 1; vb[i] = 2; end
        run_pairs(0, 56, 1'b1, "hold");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b0 || fin !== 1'b0 || busy !== 1'b0 || result !== AW'(56)) begin
                failures++;
                $display("FAIL hold_cycle%0d rdy=%b fin=%b busy=%b res=%0d exp=0,0,0,56",
                         c, in_ready, fin, busy, result);
            end
        end
        cal = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < CGES; i++) begin va[i] = i + 1; vb[i] = 3; end
        run_pairs(0, 84, 1'b0, "rearm");
    endtask

    task automatic test_reset_mid();
        cal = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        feed(4, "rst_mid");
        reset_n = 1'b0;
        #1;
        checks++;
        if (fin !== 1'b0 || abort !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL rst_mid_async fin=%b abort=%b busy=%b rdy=%b res=%0d exp all 0",
                     fin, abort, busy, in_ready, result);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < CGES; i++) begin va[i] = rand_s16(); vb[i] = rand_s16(); end
        run_pairs(0, model_sum(), 1'b0, "rst_fresh");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < CGES; i++) begin va[i] = rand_s16(); vb[i] = rand_s16(); end
            run_pairs(2, model_sum(), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_toggle();
        test_extremes();
        test_abort();
        test_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
